// File: rtl/serial_mem_responder_if.sv
// Core-side 8-bit serial bus between cpu_core (master) and the memory responder (slave).
interface serial_mem_responder_if;
    logic [7:0] out_bus;
    logic       bus_pc;
    logic       bus_mar;
    logic       bus_mdr;
    logic [7:0] in_bus;
    logic       ard_data_ready;
    logic       ard_receive_ready;

    modport master (
        output out_bus, bus_pc, bus_mar, bus_mdr,
        input  in_bus, ard_data_ready, ard_receive_ready
    );

    modport slave (
        input  out_bus, bus_pc, bus_mar, bus_mdr,
        output in_bus, ard_data_ready, ard_receive_ready
    );
endinterface

// File: rtl/serial_mem_responder.sv
// Memory-side endpoint of the core's 8-bit serial bus: captures PC/MAR addresses,
// streams instruction bytes from IMEM and services DMEM loads/stores; loader port writes either memory.
module serial_mem_responder #(
    parameter int DEPTH       = 16,
    parameter int FETCH_WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_mem_responder_if.slave bus,
    input  logic                  prog_we,
    input  logic                  prog_sel,
    input  logic [15:0]           prog_addr,
    input  logic [15:0]           prog_wdata,
    input  logic [15:0]           dbg_addr,
    output logic [15:0]           dbg_rdata,
    output logic                  busy
);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NBYTES = 2 * FETCH_WORDS;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_FETCH,
        S_DECIDE,
        S_RD_LO,
        S_RD_HI,
        S_WR_HI
    } state_e;

    typedef enum logic {
        KIND_PC,
        KIND_MAR
    } kind_e;

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_lo_q, wdata_lo_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;

    logic [15:0] imem_q [DEPTH];
    logic [15:0] dmem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic [AW-1:0] fetch_idx;
    logic [15:0]   fetch_word;
    logic [7:0]    fetch_byte;
    logic [15:0]   dmem_word;
    logic          capture;
    logic          abortable;
    logic          commit;
    logic          data_ready;
    logic          recv_ready;
    logic [7:0]    data_byte;

    // Addresses wrap by keeping only the low AW bits; the upper bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q, prog_addr, dbg_addr};

    assign word_idx   = addr_q[AW-1:0];
    assign fetch_idx  = word_idx + AW'(byte_cnt_q >> 1);
    assign fetch_word = imem_q[fetch_idx];
    assign fetch_byte = byte_cnt_q[0] ? fetch_word[15:8] : fetch_word[7:0];
    assign dmem_word  = dmem_q[word_idx];

    assign capture   = bus.bus_pc | bus.bus_mar;
    assign abortable = (state_q == S_IDLE)  || (state_q == S_FETCH) ||
                       (state_q == S_RD_LO) || (state_q == S_RD_HI);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        wdata_lo_d = wdata_lo_q;
        byte_cnt_d = byte_cnt_q;
        data_ready = 1'b0;
        data_byte  = 8'h00;
        recv_ready = 1'b1;
        commit     = 1'b0;

        unique case (state_q)
            S_IDLE: ;
            S_ADDR_HI: begin
                addr_d[15:8] = bus.out_bus;
                if (kind_q == KIND_PC) begin
                    byte_cnt_d = '0;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_DECIDE;
                end
            end
            S_FETCH: begin
                recv_ready = 1'b0;
                data_ready = 1'b1;
                data_byte  = fetch_byte;
                if (byte_cnt_q == LAST_BYTE) begin
                    state_d = S_IDLE;
                end else begin
                    byte_cnt_d = byte_cnt_q + CW'(1);
                end
            end
            S_DECIDE: begin
                if (bus.bus_mdr) begin
                    wdata_lo_d = bus.out_bus;
                    state_d    = S_WR_HI;
                end else begin
                    state_d = S_RD_LO;
                end
            end
            S_RD_LO: begin
                recv_ready = 1'b0;
                data_ready = 1'b1;
                data_byte  = dmem_word[7:0];
                state_d    = S_RD_HI;
            end
            S_RD_HI: begin
                recv_ready = 1'b0;
                data_ready = 1'b1;
                data_byte  = dmem_word[15:8];
                state_d    = S_IDLE;
            end
            S_WR_HI: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new PC/MAR flag in an output state drops that cycle's byte and restarts the capture.
        if (capture && abortable) begin
            addr_d[7:0] = bus.out_bus;
            kind_d      = bus.bus_pc ? KIND_PC : KIND_MAR;
            state_d     = S_ADDR_HI;
            data_ready  = 1'b0;
            data_byte   = 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            kind_q     <= KIND_PC;
            addr_q     <= '0;
            wdata_lo_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            addr_q     <= addr_d;
            wdata_lo_q <= wdata_lo_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // NOTE: memory arrays are intentionally not reset; contents survive rst and are filled by the loader.
    // The core commit is written last so it wins a same-word collision with the loader.
    always_ff @(posedge clk) begin
        if (prog_we && !prog_sel) begin
            imem_q[prog_addr[AW-1:0]] <= prog_wdata;
        end
        if (prog_we && prog_sel) begin
            dmem_q[prog_addr[AW-1:0]] <= prog_wdata;
        end
        if (commit && !rst) begin
            dmem_q[word_idx] <= {bus.out_bus, wdata_lo_q};
        end
    end

    assign bus.in_bus            = data_byte;
    assign bus.ard_data_ready    = data_ready;
    assign bus.ard_receive_ready = recv_ready;
    assign dbg_rdata             = dmem_q[dbg_addr[AW-1:0]];
    assign busy                  = (state_q != S_IDLE);

    a_in_bus_zero_when_idle: assert property (
        @(posedge clk) disable iff (rst) !bus.ard_data_ready |-> (bus.in_bus == 8'h00));

    a_no_send_while_receiving: assert property (
        @(posedge clk) disable iff (rst) bus.ard_data_ready |-> !bus.ard_receive_ready);

endmodule

// File: tb/tb_serial_mem_responder.sv
// Directed bench: expected bytes (value and cycle) go into a scoreboard queue; a negedge monitor checks them.
module tb_serial_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic        prog_sel = 1'b0;
    logic [15:0] prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [15:0] dbg_addr = '0;
    logic [15:0] dbg_rdata;
    logic        busy;

    serial_mem_responder_if bus ();

    serial_mem_responder #(.DEPTH(16), .FETCH_WORDS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .prog_we    (prog_we),
        .prog_sel   (prog_sel),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented byte must match the head of the scoreboard, in value and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ard_data_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got in_bus=%0h at cycle %0d, expected no byte", bus.in_bus, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("byte_value", {24'h0, bus.in_bus}, {24'h0, mon_e.data});
                    check("byte_cycle", cyc, mon_e.cyc);
                end
            end else begin
                check("in_bus_zero_when_not_ready", {24'h0, bus.in_bus}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [15:0] a, input logic [15:0] d);
        prog_we    = 1'b1;
        prog_sel   = sel;
        prog_addr  = a;
        prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    // Raises the flag(s) in cycle t with the low byte, then the high byte in t+1; returns in cycle t+2.
    task automatic send_addr(input logic pc, input logic mar, input logic [15:0] a, output int t);
        bus.bus_pc  = pc;
        bus.bus_mar = mar;
        bus.out_bus = a[7:0];
        t = cyc;
        tick();
        bus.bus_pc  = 1'b0;
        bus.bus_mar = 1'b0;
        bus.out_bus = a[15:8];
        tick();
        bus.out_bus = 8'h00;
    endtask

    task automatic expect_byte(input int c, input logic [7:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic expect_fetch(input int t, input logic [15:0] w0, input logic [15:0] w1);
        expect_byte(t + 2, w0[7:0]);
        expect_byte(t + 3, w0[15:8]);
        expect_byte(t + 4, w1[7:0]);
        expect_byte(t + 5, w1[15:8]);
    endtask

    task automatic check_dmem(input string name, input logic [15:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check(name, {16'h0, dbg_rdata}, {16'h0, exp});
    endtask

    int t;
    int t2;

    initial begin
        bus.out_bus = 8'h00;
        bus.bus_pc  = 1'b0;
        bus.bus_mar = 1'b0;
        bus.bus_mdr = 1'b0;

        // Reset values
        repeat (3) tick();
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_data_ready", {31'h0, bus.ard_data_ready}, 32'h0);
        check("reset_receive_ready", {31'h0, bus.ard_receive_ready}, 32'h1);
        check("reset_in_bus", {24'h0, bus.in_bus}, 32'h0);
        rst = 1'b0;
        tick();

        load(1'b0, 16'h0000, 16'hA1B2);
        load(1'b0, 16'h0001, 16'h0003);
        load(1'b0, 16'h000F, 16'h1234);
        load(1'b0, 16'h0004, 16'hC3D4);
        load(1'b0, 16'h0005, 16'hE5F6);
        load(1'b1, 16'h0004, 16'h9999);

        // Basic fetch at 0
        send_addr(1'b1, 1'b0, 16'h0000, t);
        expect_fetch(t, 16'hA1B2, 16'h0003);
        check("fetch_busy", {31'h0, busy}, 32'h1);
        check("fetch_receive_ready", {31'h0, bus.ard_receive_ready}, 32'h0);
        repeat (4) tick();
        check("fetch_idle_after", {31'h0, busy}, 32'h0);

        // MAR store FFFD to word 6
        send_addr(1'b0, 1'b1, 16'h0006, t);
        check("decide_receive_ready", {31'h0, bus.ard_receive_ready}, 32'h1);
        bus.bus_mdr = 1'b1;
        bus.out_bus = 8'hFD;
        tick();
        bus.bus_mdr = 1'b0;
        bus.out_bus = 8'hFF;
        check("wr_hi_receive_ready", {31'h0, bus.ard_receive_ready}, 32'h1);
        tick();
        bus.out_bus = 8'h00;
        check_dmem("store_dmem6", 16'h0006, 16'hFFFD);
        check("store_idle_after", {31'h0, busy}, 32'h0);

        // MAR load of word 6
        send_addr(1'b0, 1'b1, 16'h0006, t);
        expect_byte(t + 3, 8'hFD);
        expect_byte(t + 4, 8'hFF);
        repeat (3) tick();
        check("load_idle_after", {31'h0, busy}, 32'h0);

        // High address byte is ignored: FF06 aliases word 6
        send_addr(1'b0, 1'b1, 16'hFF06, t);
        expect_byte(t + 3, 8'hFD);
        expect_byte(t + 4, 8'hFF);
        repeat (3) tick();

        // Wrap from word 15 to word 0
        load(1'b0, 16'h0000, 16'h5678);
        send_addr(1'b1, 1'b0, 16'h000F, t);
        expect_fetch(t, 16'h1234, 16'h5678);
        repeat (4) tick();

        // Abort: new PC during fetch byte 1
        send_addr(1'b1, 1'b0, 16'h0000, t);
        expect_byte(t + 2, 8'h78);
        tick();
        bus.bus_pc  = 1'b1;
        bus.out_bus = 8'h04;
        #1;
        check("abort_data_ready_low", {31'h0, bus.ard_data_ready}, 32'h0);
        check("abort_in_bus_zero", {24'h0, bus.in_bus}, 32'h0);
        t2 = cyc;
        tick();
        bus.bus_pc  = 1'b0;
        bus.out_bus = 8'h00;
        tick();
        expect_fetch(t2, 16'hC3D4, 16'hE5F6);
        repeat (4) tick();

        // PC has priority over MAR (DMEM[4] differs from IMEM[4])
        send_addr(1'b1, 1'b1, 16'h0004, t);
        expect_fetch(t, 16'hC3D4, 16'hE5F6);
        repeat (4) tick();
        check("priority_idle_after", {31'h0, busy}, 32'h0);

        // Reset during WR_HI abandons the store
        load(1'b1, 16'h0009, 16'hAAAA);
        send_addr(1'b0, 1'b1, 16'h0009, t);
        bus.bus_mdr = 1'b1;
        bus.out_bus = 8'h55;
        tick();
        bus.bus_mdr = 1'b0;
        bus.out_bus = 8'h66;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_bus = 8'h00;
        check("rst_wr_busy", {31'h0, busy}, 32'h0);
        check("rst_wr_receive_ready", {31'h0, bus.ard_receive_ready}, 32'h1);
        check("rst_wr_data_ready", {31'h0, bus.ard_data_ready}, 32'h0);
        check_dmem("rst_wr_dmem9_unchanged", 16'h0009, 16'hAAAA);

        // Loader and core commit collide on DMEM[3]: core wins
        load(1'b1, 16'h0003, 16'h0BAD);
        check_dmem("loader_dmem3", 16'h0003, 16'h0BAD);
        send_addr(1'b0, 1'b1, 16'h0003, t);
        bus.bus_mdr = 1'b1;
        bus.out_bus = 8'h22;
        tick();
        bus.bus_mdr = 1'b0;
        bus.out_bus = 8'h22;
        prog_we     = 1'b1;
        prog_sel    = 1'b1;
        prog_addr   = 16'h0003;
        prog_wdata  = 16'h1111;
        tick();
        prog_we     = 1'b0;
        bus.out_bus = 8'h00;
        check_dmem("collision_dmem3", 16'h0003, 16'h2222);

        repeat (3) tick();
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_mem_responder.md
Name: serial_mem_responder

Overview:
- Synthesizable memory-side endpoint of the CPU core's 8-bit serial bus. Replaces the bench's hand-written responder for board bring-up.
- Holds an instruction memory (IMEM) and a data memory (DMEM) of 16-bit words.
- Captures PC and MAR addresses shifted out by the core, streams instruction bytes back, and services DMEM loads and stores.
- Sits between cpu_core and the host/Arduino loader port.

Parameters:
DEPTH, 16, words per memory (IMEM and DMEM each); power of two
FETCH_WORDS, 2, words streamed per PC fetch (opcode word + immediate word)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
out_bus  in  8  byte driven by core (address/store data)
bus_pc  in  1  core presents PC, low byte this cycle
bus_mar  in  1  core presents MAR, low byte this cycle
bus_mdr  in  1  core presents store data, low byte this cycle
in_bus  out  8  byte driven to core
ard_data_ready  out  1  in_bus valid this cycle
ard_receive_ready  out  1  responder accepting bytes from core
prog_we  in  1  loader write strobe
prog_sel  in  1  0=IMEM, 1=DMEM
prog_addr  in  16  loader word address
prog_wdata  in  16  loader word data
dbg_addr  in  16  DMEM debug read address
dbg_rdata  out  16  DMEM[dbg_addr], combinational
busy  out  1  state != IDLE

Behaviour:
- Fixed at decision: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; in_bus=0; ard_data_ready=0; ard_receive_ready=1; busy=0.
  - Memory contents are NOT cleared by reset.
  - Reset mid-transaction abandons the transaction. A partial store is never committed.
- Byte order is little-endian: low byte first. Addresses use the low log2(DEPTH) bits, so out-of-range addresses wrap.
- States: IDLE, ADDR_HI, FETCH, DECIDE, RD_LO, RD_HI, WR_HI.
- IDLE:
  - bus_pc=1: latch addr[7:0]=out_bus, kind=PC, go ADDR_HI.
  - Else bus_mar=1: same, kind=MAR.
  - bus_pc has priority when both are high.
- ADDR_HI: latch addr[15:8]=out_bus.
  - kind=PC: go FETCH with byte counter 0.
  - kind=MAR: go DECIDE.
- FETCH:
  - Emits 2*FETCH_WORDS bytes on consecutive cycles, with ard_data_ready=1 on each.
  - Byte k = IMEM[(addr + k/2) mod DEPTH], low byte when k is even, high byte when k is odd.
  - With a flag raised at cycle T, bytes appear in cycles T+2 .. T+1+2*FETCH_WORDS. Then return to IDLE.
- DECIDE (cycle T+2):
  - bus_mdr=1: latch wdata[7:0]=out_bus, go WR_HI.
  - Otherwise: go RD_LO.
- WR_HI: at the end of this cycle, write DMEM[addr]={out_bus, wdata[7:0]}. Go IDLE.
- RD_LO / RD_HI: in_bus = DMEM[addr][7:0], then [15:8]. ard_data_ready=1 in both (cycles T+3, T+4). Go IDLE.
- ard_receive_ready=1 in IDLE, ADDR_HI, DECIDE, WR_HI; 0 in FETCH, RD_LO, RD_HI.
- in_bus=0 whenever ard_data_ready=0.
- Abort: bus_pc or bus_mar rising in FETCH/RD_LO/RD_HI abandons output that cycle and is treated exactly as the IDLE capture. ard_data_ready=0 that cycle.
- Loader port:
  - prog_we writes the selected memory at prog_addr at any time.
  - If it collides with a WR_HI commit to the same DMEM word in the same cycle, the core write wins.
- Memory reads in FETCH/RD use current contents, so a same-cycle loader write is not visible until the next cycle.

Test Plan:
- IMEM[0]=16'hA1B2, IMEM[1]=16'h0003; bus_pc high with bytes 00,00 -> cycles T+2..T+5 in_bus=B2,A1,03,00, ard_data_ready=1; IDLE at T+6.
- MAR store: bus_mar with bytes 06,00, then bus_mdr with bytes FD,FF -> dbg_addr=6 reads 16'hFFFD; ard_data_ready never asserted.
- MAR load after the previous store: bus_mar with bytes 06,00, bus_mdr=0 at T+2 -> in_bus=FD at T+3, FF at T+4, ard_data_ready=1 in both.
- Wrap: fetch at address 16'h000F with DEPTH=16, IMEM[15]=16'h1234, IMEM[0]=16'h5678 -> bytes 34,12,78,56.
- Abort and priority:
  - bus_pc asserted during FETCH byte 1 -> ard_data_ready=0 that cycle; new fetch starts from the newly captured address.
  - bus_pc and bus_mar high together -> PC path taken.
- Reset mid-WR_HI, then loader collision:
  - rst during WR_HI -> DMEM word unchanged, outputs return to reset values.
  - prog_we to DMEM[3]=16'h1111 in the same cycle as a core commit of 16'h2222 to word 3 -> DMEM[3]=16'h2222.
